// File: rtl/stage_controller_pkg.sv
// Shared stage broadcast encoding for the processing-unit array and its sequencer.
package stage_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  typedef logic [STAGE_WIDTH-1:0] stage_t;

  localparam stage_t STAGE_IDLE                = 3'd0;
  localparam stage_t STAGE_MEASUREMENT_LOADING = 3'd1;
  localparam stage_t STAGE_GROW                = 3'd2;
  localparam stage_t STAGE_MERGE               = 3'd3;
  localparam stage_t STAGE_RESULT_VALID        = 3'd4;

endpackage

// File: rtl/stage_controller_status.sv
// Registered OR reduction of the per-PE busy and odd flags (one cycle of latency).
module stage_status_reducer
  import stage_controller_pkg::*;
#(
  parameter int PU_COUNT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PU_COUNT-1:0] busy,
  input  logic [PU_COUNT-1:0] odd,
  output logic                busy_any_q,
  output logic                odd_any_q
);

  // stage p0 -> p1: wide OR, registered so the array fan-in stays off the FSM path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_any_q <= 1'b0;
      odd_any_q  <= 1'b0;
    end else begin
      busy_any_q <= |busy;
      odd_any_q  <= |odd;
    end
  end

endmodule

// File: rtl/stage_controller.sv
// Central sequencer: LOAD, alternating MERGE/GROW rounds, then RESULT_VALID.
// Optional cycle counter enabled by defining STAGE_CTRL_CYCLE_COUNTER_EN.
module stage_controller
  import stage_controller_pkg::*;
#(
  parameter int PU_COUNT      = 64,
  parameter int MAX_ITERATION = 255,
  parameter int ITER_WIDTH    = 8,
  parameter int LOAD_CYCLES   = 2,
  parameter int MERGE_SETTLE  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [PU_COUNT-1:0]    busy,
  input  logic [PU_COUNT-1:0]    odd,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [ITER_WIDTH-1:0]  iteration_count,
  output logic                   timeout
`ifdef STAGE_CTRL_CYCLE_COUNTER_EN
  ,
  output logic [31:0]            cycle_count
`endif
);

  localparam int LOAD_W   = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int SETTLE_W = $clog2(MERGE_SETTLE + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_GROW  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [LOAD_W-1:0]     load_cnt_q, load_cnt_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic                  timeout_q, timeout_d;
  logic [STAGE_WIDTH-1:0] stage_q;
  logic                  busy_any_q;
  logic                  odd_any_q;
  logic                  start_fire;

  function automatic logic [STAGE_WIDTH-1:0] stage_of(input logic [2:0] s);
    case (s)
      S_LOAD:  return STAGE_MEASUREMENT_LOADING;
      S_MERGE: return STAGE_MERGE;
      S_GROW:  return STAGE_GROW;
      S_DONE:  return STAGE_RESULT_VALID;
      default: return STAGE_IDLE;
    endcase
  endfunction

  stage_status_reducer #(
    .PU_COUNT (PU_COUNT)
  ) u_reducer (
    .clk        (clk),
    .reset      (reset),
    .busy       (busy),
    .odd        (odd),
    .busy_any_q (busy_any_q),
    .odd_any_q  (odd_any_q)
  );

  assign start_ready     = (state_q == S_IDLE);
  assign result_valid    = (state_q == S_DONE);
  assign start_fire      = start_valid && start_ready;
  assign global_stage    = stage_q;
  assign iteration_count = iter_q;
  assign timeout         = timeout_q;

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    settle_cnt_d = settle_cnt_q;
    iter_d       = iter_q;
    timeout_d    = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start_fire) begin
          state_d    = S_LOAD;
          load_cnt_d = LOAD_W'(LOAD_CYCLES - 1);
          iter_d     = '0;
          timeout_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_cnt_q == '0) begin
          state_d      = S_MERGE;
          settle_cnt_d = SETTLE_W'(MERGE_SETTLE);
        end else begin
          load_cnt_d = load_cnt_q - LOAD_W'(1);
        end
      end
      S_MERGE: begin
        // busy_any_q lags the broadcast by the PE pipeline, so it is ignored until settled
        if (settle_cnt_q != '0) begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end else if (!busy_any_q) begin
          if (!odd_any_q) begin
            state_d = S_DONE;
          end else if (iter_q == ITER_WIDTH'(MAX_ITERATION)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end else begin
            state_d = S_GROW;
          end
        end
      end
      S_GROW: begin
        // PEs only act on the first GROW cycle, so this state never lasts longer than one
        state_d      = S_MERGE;
        settle_cnt_d = SETTLE_W'(MERGE_SETTLE);
        iter_d       = iter_q + ITER_WIDTH'(1);
      end
      S_DONE: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // stage p0 -> p1: FSM state and the registered stage broadcast update together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      load_cnt_q   <= '0;
      settle_cnt_q <= '0;
      iter_q       <= '0;
      timeout_q    <= 1'b0;
      stage_q      <= STAGE_IDLE;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      iter_q       <= iter_d;
      timeout_q    <= timeout_d;
      stage_q      <= stage_of(state_d);
    end
  end

`ifdef STAGE_CTRL_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // The accept cycle itself is the first counted cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q <= '0;
    end else if (start_fire) begin
      cycle_cnt_q <= 32'd1;
    end else if (state_q == S_LOAD || state_q == S_MERGE || state_q == S_GROW) begin
      cycle_cnt_q <= sat_inc32(cycle_cnt_q);
    end
  end

  assign cycle_count = cycle_cnt_q;
`endif

endmodule
